// File: rtl/mac_result_collector.sv
// mac_result_collector: FWFT result FIFO with frame tracking; MAC_COLLECT_MAX_EN adds running signed max
module mac_result_collector #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_W-1:0]        mac_result,
  input  logic                     mac_valid,
  input  logic [7:0]               frame_len,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  output logic                     frame_done,
  output logic [DATA_W-1:0]        max_result
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  typedef enum logic {IDLE, COLLECT} state_t;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  state_t state, state_nx;
  logic [7:0] cnt, cnt_nx;
  logic done_nx, rd, wr;
  logic [8:0] eff_len;
  assign empty     = level == '0;
  assign full      = level == FULL_LVL;
  assign out_valid = !empty;
  assign out_data  = empty ? '0 : mem[rptr];
  assign rd        = out_valid && out_ready;
  assign wr        = mac_valid && (!full || rd);
  assign eff_len   = frame_len == 8'd0 ? 9'd256 : {1'b0, frame_len};
  // storage array written on accepted writes; never reset, masked by empty
  always_ff @(posedge clk)
    if (wr) mem[wptr] <= mac_result;
  // pointers, occupancy and sticky overflow
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wptr     <= '0;
      rptr     <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      wptr     <= wr ? wptr + 1'b1 : wptr;
      rptr     <= rd ? rptr + 1'b1 : rptr;
      level    <= level + {{AW{1'b0}}, wr} - {{AW{1'b0}}, rd};
      overflow <= overflow || (mac_valid && !wr);
    end
  // frame state register and completion pulse
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      frame_done <= done_nx;
    end
  // a write completes the frame once count reaches the current effective length
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    done_nx  = 1'b0;
    if (wr) begin
      done_nx  = ({1'b0, cnt} + 9'd1) >= eff_len;
      state_nx = done_nx ? IDLE : COLLECT;
      cnt_nx   = done_nx ? 8'd0 : cnt + 8'd1;
    end
  end
`ifdef MAC_COLLECT_MAX_EN
  // running signed maximum, reloaded on the first write of each frame
  always_ff @(posedge clk or posedge reset)
    if (reset) max_result <= '0;
    else if (wr && (state == IDLE || $signed(mac_result) > $signed(max_result))) max_result <= mac_result;
`else
  assign max_result = '0;
`endif
endmodule

// File: tb/tb_mac_result_collector.sv
// tb_mac_result_collector: directed plus random checks against a queue-based reference model
module tb_mac_result_collector;
  logic clk = 1'b0, reset = 1'b1;
  logic [31:0] mac_result = '0;
  logic mac_valid = 1'b0, out_ready = 1'b0;
  logic [7:0] frame_len = 8'd3;
  logic [31:0] out_data, max_result;
  logic out_valid, full, empty, overflow, frame_done;
  logic [3:0] level;
  int errors = 0, checks = 0;
  logic [31:0] q[$];
  int n = 0;
  bit ovf = 0, dn = 0;
  logic signed [31:0] mx = '0;

  mac_result_collector #(.DEPTH(8), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .mac_result(mac_result), .mac_valid(mac_valid),
    .frame_len(frame_len), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .level(level), .full(full), .empty(empty),
    .overflow(overflow), .frame_done(frame_done), .max_result(max_result));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    n = 0; ovf = 0; dn = 0; mx = '0;
  endtask

  task automatic model_edge(input bit v, input logic [31:0] d, input logic [7:0] len, input bit rdy);
    bit rd, wr;
    int eff;
    rd = q.size() > 0 && rdy;
    wr = v && (q.size() < 8 || rd);
    if (rd) void'(q.pop_front());
    if (wr) q.push_back(d);
    if (v && !wr) ovf = 1;
    dn = 0;
    if (wr) begin
      eff = len == 0 ? 256 : int'(len);
      mx = (n == 0 || $signed(d) > mx) ? $signed(d) : mx;
      n++;
      if (n >= eff) begin dn = 1; n = 0; end
    end
  endtask

  task automatic check_all();
    logic [31:0] emx;
`ifdef MAC_COLLECT_MAX_EN
    emx = mx;
`else
    emx = '0;
`endif
    chk("level", 32'(level), 32'(q.size()));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("full", 32'(full), 32'(q.size() == 8));
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("out_data", out_data, q.size() == 0 ? 32'd0 : q[0]);
    chk("overflow", 32'(overflow), 32'(ovf));
    chk("frame_done", 32'(frame_done), 32'(dn));
    chk("max_result", max_result, emx);
  endtask

  task automatic step(input bit v, input logic [31:0] d, input logic [7:0] len, input bit rdy);
    mac_valid = v; mac_result = d; frame_len = len; out_ready = rdy;
    @(posedge clk);
    model_edge(v, d, len, rdy);
    #1;
    check_all();
  endtask

  initial begin
    model_reset();
    #2 check_all();
    @(posedge clk); @(posedge clk); #1 reset = 1'b0;
    check_all();
    // three-result frame, then drain
    step(1, 32'd8, 8'd3, 0);
    step(1, 32'd23, 8'd3, 0);
    step(1, 32'd35, 8'd3, 0);
    step(0, 32'd0, 8'd3, 0);
    for (int i = 0; i < 4; i++) step(0, 32'd0, 8'd3, 1);
    // overflow: ten writes into eight slots, then read all back
    for (int i = 0; i < 10; i++) step(1, 32'(100 + i), 8'd4, 0);
    for (int i = 0; i < 9; i++) step(0, 32'd0, 8'd4, 1);
    // full with simultaneous read and write
    for (int i = 0; i < 8; i++) step(1, 32'(200 + i), 8'd4, 0);
    step(1, 32'd300, 8'd4, 1);
    for (int i = 0; i < 9; i++) step(0, 32'd0, 8'd4, 1);
    // single-result frames with signed values
    step(1, -32'sd5, 8'd1, 1);
    step(1, 32'sd7, 8'd1, 1);
    step(1, -32'sd2, 8'd1, 1);
    step(1, 32'sd3, 8'd1, 1);
    step(0, 32'd0, 8'd1, 1);
    // asynchronous reset mid-frame with five entries held
    for (int i = 0; i < 5; i++) step(1, 32'(50 + i), 8'd8, 0);
    #3 reset = 1'b1;
    model_reset();
    #1 check_all();
    @(posedge clk); #1 reset = 1'b0;
    check_all();
    step(1, -32'sd9, 8'd2, 0);
    step(1, -32'sd4, 8'd2, 0);
    step(0, 32'd0, 8'd2, 1);
    // random traffic, including mid-frame length changes and length 0
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, $urandom, ($urandom_range(0, 19) == 0) ? 8'd0 : 8'($urandom_range(1, 5)), $urandom_range(0, 2) != 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mac_result_collector.md
MAC_RESULT_COLLECTOR -- requirements
Module: mac_result_collector

Interface
REQ-001 The block SHALL have the parameter DEPTH, default 8, meaning FIFO entry count; it SHALL be a power of two, minimum 2.
REQ-002 The block SHALL have the parameter DATA_W, default 32, meaning the result width, matching the MAC unit result.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 mac_result  input  DATA_W  accumulated result from the MAC unit.
REQ-006 mac_valid  input  1  mac_result valid this cycle; driven by the MAC valid_out; no backpressure to the MAC.
REQ-007 frame_len  input  8  results per frame; 0 means 256; sampled on every accepted write.
REQ-008 out_data  output  DATA_W  head-of-FIFO data.
REQ-009 out_valid  output  1  out_data valid.
REQ-010 out_ready  input  1  downstream accepts out_data.
REQ-011 level  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-012 full / empty  output  1 each  level==DEPTH / level==0.
REQ-013 overflow  output  1  sticky flag: a result was dropped.
REQ-014 frame_done  output  1  one-cycle pulse: frame completed.
REQ-015 max_result  output  DATA_W  running signed maximum of the current frame (see Configuration).

Function
REQ-016 The FIFO SHALL be first-word-fall-through, with out_valid = !empty and out_data = the oldest entry, both driven from registers/storage with no combinational path from mac_result.
REQ-017 A write SHALL be accepted when mac_valid=1 and (!full or (out_valid and out_ready)) in the same cycle.
REQ-018 An accepted write at edge k SHALL make the result visible on out_data/out_valid in the cycle after edge k when the FIFO was empty; the latency SHALL be 1 cycle.
REQ-019 A read SHALL occur when out_valid and out_ready are both 1; the head then advances at that edge.
REQ-020 Simultaneous read and write SHALL leave level unchanged, including when full.
REQ-021 mac_valid while full without a same-cycle read SHALL drop the result, leave the FIFO unchanged, set overflow, and not count toward the frame.
REQ-022 out_ready while empty SHALL have no effect.
REQ-023 Read and write pointers SHALL wrap modulo DEPTH without disturbing data.
REQ-024 The frame FSM SHALL have two states: IDLE (frame_cnt=0) and COLLECT.
REQ-025 IDLE->COLLECT SHALL occur on an accepted write when the effective frame_len > 1.
REQ-026 In COLLECT, each accepted write SHALL increment frame_cnt.
REQ-027 The write making frame_cnt+1 equal the effective frame_len SHALL return the FSM to IDLE, clear frame_cnt, and pulse frame_done in the following cycle.
REQ-028 With frame_len=1, every accepted write SHALL pulse frame_done and the FSM SHALL stay in IDLE.
REQ-029 frame_done SHALL never be high for two consecutive cycles unless two consecutive frames each complete on consecutive edges.
REQ-030 A change of frame_len mid-frame SHALL take effect on the next accepted write; if frame_cnt+1 is greater than or equal to the new length, that write SHALL complete the frame.

Reset
REQ-031 While reset=1, the block SHALL hold: FIFO empty (level=0, empty=1, full=0, out_valid=0), out_data=0, overflow=0, frame_done=0, max_result=0, FSM in IDLE, frame_cnt=0.
REQ-032 Reset asserted mid-operation SHALL discard all FIFO contents and any partial frame immediately, without waiting for a clock edge.

Configuration
REQ-033 The macro MAC_COLLECT_MAX_EN SHALL control the running-maximum feature.
REQ-034 With MAC_COLLECT_MAX_EN defined, max_result SHALL be updated on each accepted write to the signed maximum of the frame's results so far, and be loaded with the write's value on the first write of a frame.
REQ-035 Without MAC_COLLECT_MAX_EN defined, the max_result port SHALL remain and be tied to 0, and no comparator logic SHALL be generated.

Verification
REQ-036 Reset, then mac_valid for 3 cycles with 8, 23, 35, frame_len=3, out_ready=0 -> level=3, frame_done pulses once the cycle after 35, overflow=0, max_result=35 (MAX_EN).
REQ-037 Then out_ready=1 -> out_data reads 8, 23, 35 on consecutive cycles, then empty=1 and out_valid=0.
REQ-038 With out_ready=0, write 10 values into DEPTH=8 -> full=1 after the 8th; the 9th and 10th are dropped; overflow=1 and stays set; reads return the first 8 in order.
REQ-039 With the FIFO full, mac_valid=1 and out_ready=1 in the same cycle -> the write is accepted, level stays 8, and the oldest entry is output.
REQ-040 frame_len=1 with 4 writes of -5, 7, -2, 3 -> 4 frame_done pulses, and max_result equals each written value (MAX_EN).
REQ-041 Assert reset asynchronously mid-frame with level=5 -> all outputs immediately at reset values, and the next frame restarts at frame_cnt=0.
